// File: rtl/fft_sdf_ctrl.sv
// -----------------------------------------------------------------------------
// fft_sdf_ctrl
//
// Sequencer for a radix-2 single-path delay-feedback FFT pipeline. Stage s owns
// a delay line of depth D_s = N >> (s+1). This block has no datapath. It only
// produces the per-stage mux selects, the twiddle exponent applied after
// stage 0, the shared clock enable, the flush control and the output framing.
//
// Ports
//   clk        rising-edge clock
//   clear      asynchronous active-low reset; all state and outputs go to 0
//   in_valid   an input sample is present this cycle
//   in_sof     the in_valid sample is frame index 0
//   pipe_en    clock enable for every stage delay line (the accept strobe)
//   zero_in    stage 0 takes 0 instead of the input sample (flush)
//   sel        sel[s]:   0 = load delay line, 1 = butterfly / feed back difference
//   sel_1      sel_1[s]: 0 = emit butterfly sum, 1 = emit delayed word
//   tw_idx     exponent k of W_N^k for the word leaving stage 0
//   out_valid  the last stage emits a valid bin this cycle
//   out_sof    the emitted bin is the first of its frame
//   out_idx    bin number of the emitted bin, in bit-reversed order
//   frame_err  one-cycle pulse on an in_sof that arrives with cnt != 0
//
// A single counter cnt tracks the frame position of the sample being accepted.
// Stage s sees the same stream delayed by O_s = sum_{k<s} D_k = N - (N >> s)
// samples, so its local count is c_s = cnt - O_s (mod N).
// -----------------------------------------------------------------------------
module fft_sdf_ctrl #(
  parameter int N     = 4,
  parameter int LOG2N = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             pipe_en,
  output logic             zero_in,
  output logic [LOG2N-1:0] sel,
  output logic [LOG2N-1:0] sel_1,
  output logic [LOG2N-2:0] tw_idx,
  output logic             out_valid,
  output logic             out_sof,
  output logic [LOG2N-1:0] out_idx,
  output logic             frame_err
);

  localparam int CW   = LOG2N;
  localparam int TW_W = LOG2N - 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // FILL accepts its last sample at this count. FLUSH runs at counts 0 to
  // N-2, so this is also the count of the final flush cycle.
  localparam logic [CW-1:0] CNT_LAST_FILL = CW'(N - 2);
  localparam logic [CW-1:0] HALF     = CW'(N / 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LOG2N-1:0] sel_q, sel_d;
  logic [LOG2N-1:0] sel_1_q, sel_1_d;
  logic [TW_W-1:0] tw_q, tw_d;

  logic            sof_take;    // in_valid qualified by in_sof
  logic            misaligned;  // in_sof in an active frame away from index 0
  logic            flush_last;  // final cycle of the flush
  logic [CW-1:0]   c_s;         // stage-local count, scratch for the select loop
  logic [CW-1:0]   c_1;         // stage-1 local count
  logic [CW-1:0]   m;           // natural-order bin number leaving the pipe

  function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] x);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < CW; i++) begin
      r[i] = x[CW-1-i];
    end
    return r;
  endfunction

  assign sof_take   = in_valid & in_sof;
  assign misaligned = sof_take & (cnt_q != '0) &
                      ((state_q == ST_FILL) | (state_q == ST_RUN));
  assign flush_last = (state_q == ST_FLUSH) & (cnt_q == CNT_LAST_FILL);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      sel_1_q <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Selects and twiddle move only when the pipeline advances, so a stall
      // freezes them together with the delay lines.
      if (pipe_en) begin
        sel_q   <= sel_d;
        sel_1_q <= sel_1_d;
        tw_q    <= tw_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in an always_comb gets a default first; a
  // path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        // The sof sample is accepted here as index 0; in_valid alone is dropped.
        if (sof_take) begin
          state_d = ST_FILL;
          cnt_d   = CNT_ONE;
        end
      end
      ST_FILL, ST_RUN: begin
        if (in_valid) begin
          if (misaligned) begin
            // Resync: this sample becomes index 0 and the partial frame is
            // discarded by refilling the pipe.
            state_d = ST_FILL;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if ((state_q == ST_FILL) && (cnt_q == CNT_LAST_FILL)) begin
              state_d = ST_RUN;
            end
          end
        end else if ((state_q == ST_RUN) && (cnt_q == '0)) begin
          // Stream ended on a frame boundary: drain the pipe.
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_last) begin
          if (sof_take) begin
            state_d = ST_FILL;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Select and twiddle values for the position the pipeline moves to next.
  // IDLE parks everything at 0. While FILL has not yet reached stage s
  // (cnt < O_s), that stage only loads and passes its delayed word.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_d   = '0;
    sel_1_d = '0;
    tw_d    = '0;
    c_s     = '0;
    c_1     = cnt_d - HALF;
    if (state_d != ST_IDLE) begin
      for (int s = 0; s < LOG2N; s++) begin
        c_s = cnt_d - CW'(N - (N >> s));
        if ((state_d == ST_FILL) && (cnt_d < CW'(N - (N >> s)))) begin
          sel_d[s]   = 1'b0;
          sel_1_d[s] = 1'b1;
        end else begin
          sel_d[s]   = c_s[LOG2N-1-s];
          sel_1_d[s] = ~c_s[LOG2N-1-s];
        end
      end
      // Difference words from stage 0 reach stage 1 at c_1 in [D_0, N). That
      // range is cnt < N/2, where stage 1 is still filling during FILL, so
      // the twiddle stays 0 there.
      if ((state_d != ST_FILL) && (c_1 >= HALF)) begin
        tw_d = TW_W'(c_1 - HALF);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pipe_en   = 1'b0;
    zero_in   = 1'b0;
    out_valid = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      // The reset term keeps pipe_en low while clear is asserted, even with a
      // sof sample on the input.
      ST_IDLE:  pipe_en = clear & sof_take;
      ST_FILL: begin
        pipe_en   = in_valid;
        frame_err = misaligned;
      end
      ST_RUN: begin
        pipe_en   = in_valid;
        out_valid = in_valid & ~misaligned;
        frame_err = misaligned;
      end
      ST_FLUSH: begin
        pipe_en   = 1'b1;
        out_valid = 1'b1;
        // A sof on the final flush cycle is a real sample for the next frame.
        zero_in   = ~(flush_last & sof_take);
      end
      default: begin
        pipe_en = 1'b0;
      end
    endcase
  end

  // m = cnt - (N-1) mod N, which is cnt + 1 mod N.
  assign m       = cnt_q + CNT_ONE;
  assign out_idx = out_valid ? bitrev(m) : '0;
  assign out_sof = out_valid & (m == '0);

  assign sel    = sel_q;
  assign sel_1  = sel_1_q;
  assign tw_idx = tw_q;

endmodule
